// File: rtl/uart_frame_decoder_pkg.sv
// Shared definitions for the UART firmware-update frame decoder:
// FSM state encodings, drop-reason codes and the default frame marker.
package uart_frame_decoder_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_CHK   = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_BAD_CHK = 2'd0,
        ERR_BAD_LEN = 2'd1,
        ERR_GAP     = 2'd2,
        ERR_LOST    = 2'd3
    } err_t;

    // Frame is good when the running sum plus the check byte wraps to zero.
    function automatic logic chk_ok(input logic [7:0] sum, input logic [7:0] chk);
        logic [7:0] total;
        total = sum + chk;
        return total == 8'd0;
    endfunction

endpackage

// File: rtl/uart_frame_decoder_payload_ram.sv
// Payload buffer: one write port, one synchronous read port, 8 bits x DEPTH.
// Read register is cleared by reset so the downstream data bus starts at zero.
module uart_frame_decoder_payload_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= 8'd0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_frame_decoder.sv
// Frames SYNC/CMD/LEN/payload/CHK out of the receiver byte stream, holds the
// payload until the checksum passes, then streams it to the flash writer.
module uart_frame_decoder
    import uart_frame_decoder_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         MAX_LEN   = 64,
    parameter int         AW        = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_eop,
    output logic       frm_valid,
    output logic [7:0] frm_cmd,
    output logic [8:0] frm_len,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       err_valid,
    output logic [1:0] err_code
);

    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    state_t     state;
    state_t     state_next;
    logic [7:0] cmd_q;
    logic [7:0] sum;
    logic [8:0] len_q;
    logic [8:0] wr_cnt;
    logic [8:0] rd_ptr;
    logic       wr_en;
    logic       rd_en;
    logic       frm_set;
    logic       err_set;
    err_t       err_next;

    logic [8:0] rx_len;
    logic       rx_take;
    logic       last_wr;
    logic       more_rd;
    logic       out_fire;

    assign rx_len   = {1'b0, rx_data};
    assign rx_take  = rx_valid && !rx_eop;
    assign last_wr  = (wr_cnt == len_q - 9'd1);
    assign more_rd  = (rd_ptr != len_q);
    // Downstream handshake: a byte moves on a cycle where out_valid && out_ready;
    // while out_valid is high and out_ready low, data/last are held unchanged.
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        frm_set    = 1'b0;
        err_set    = 1'b0;
        err_next   = ERR_BAD_CHK;
        case (state)
            ST_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (rx_eop) begin
                    err_set    = 1'b1;
                    err_next   = ERR_GAP;
                    state_next = ST_IDLE;
                end else if (rx_valid) begin
                    state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_eop) begin
                    err_set    = 1'b1;
                    err_next   = ERR_GAP;
                    state_next = ST_IDLE;
                end else if (rx_valid) begin
                    if (rx_len > MAX_LEN_W) begin
                        err_set    = 1'b1;
                        err_next   = ERR_BAD_LEN;
                        state_next = ST_IDLE;
                    end else if (rx_len == 9'd0) begin
                        state_next = ST_CHK;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_eop) begin
                    err_set    = 1'b1;
                    err_next   = ERR_GAP;
                    state_next = ST_IDLE;
                end else if (rx_valid) begin
                    wr_en = 1'b1;
                    if (last_wr) begin
                        state_next = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (rx_eop) begin
                    err_set    = 1'b1;
                    err_next   = ERR_GAP;
                    state_next = ST_IDLE;
                end else if (rx_valid) begin
                    if (chk_ok(sum, rx_data)) begin
                        frm_set    = 1'b1;
                        state_next = (len_q == 9'd0) ? ST_IDLE : ST_DRAIN;
                    end else begin
                        err_set    = 1'b1;
                        err_next   = ERR_BAD_CHK;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                // A new frame cannot start until the buffer is empty, so any byte is lost.
                if (rx_valid) begin
                    err_set  = 1'b1;
                    err_next = ERR_LOST;
                end
                rd_en = (!out_valid || out_ready) && more_rd;
                if (out_fire && out_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frm_valid <= 1'b0;
            frm_cmd   <= 8'd0;
            frm_len   <= 9'd0;
            err_valid <= 1'b0;
            err_code  <= 2'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            cmd_q     <= 8'd0;
            sum       <= 8'd0;
            len_q     <= 9'd0;
            wr_cnt    <= 9'd0;
            rd_ptr    <= 9'd0;
        end else begin
            frm_valid <= frm_set;
            err_valid <= err_set;
            if (err_set) begin
                err_code <= err_next;
            end
            if (frm_set) begin
                frm_cmd <= cmd_q;
                frm_len <= len_q;
                rd_ptr  <= 9'd0;
            end
            case (state)
                ST_CMD: begin
                    if (rx_take) begin
                        cmd_q <= rx_data;
                        sum   <= rx_data;
                    end
                end
                ST_LEN: begin
                    if (rx_take) begin
                        len_q  <= rx_len;
                        sum    <= sum + rx_data;
                        wr_cnt <= 9'd0;
                    end
                end
                ST_DATA: begin
                    if (rx_take) begin
                        sum    <= sum + rx_data;
                        wr_cnt <= wr_cnt + 9'd1;
                    end
                end
                ST_DRAIN: begin
                    // Read is issued one cycle ahead; out_valid rises with the RAM output.
                    if (rd_en) begin
                        out_valid <= 1'b1;
                        out_last  <= (rd_ptr == len_q - 9'd1);
                        rd_ptr    <= rd_ptr + 9'd1;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    uart_frame_decoder_payload_ram #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt[AW-1:0]),
        .wr_data (rx_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: a table of single frames plus
// hand sequences for reset mid-frame, eop abort, max length and drain stalls.
module tb_uart_frame_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_eop = 1'b0;
    logic       out_ready = 1'b1;
    logic       frm_valid;
    logic [7:0] frm_cmd;
    logic [8:0] frm_len;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       err_valid;
    logic [1:0] err_code;

    uart_frame_decoder #(
        .SYNC_BYTE (8'hA5),
        .MAX_LEN   (64),
        .AW        (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_eop    (rx_eop),
        .frm_valid (frm_valid),
        .frm_cmd   (frm_cmd),
        .frm_len   (frm_len),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .err_valid (err_valid),
        .err_code  (err_code)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         frm_cnt = 0;
    int         err_cnt = 0;
    int         out_cnt = 0;
    int         last_cnt = 0;
    int         frm_cyc = 0;
    int         first_out_cyc = -1;
    int         last_out_cyc = 0;
    int         got_cmd = 0;
    int         got_len = 0;
    int         got_code = 0;
    logic       hold_prev = 1'b0;
    logic [7:0] hold_data = 8'd0;
    logic       hold_last = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- monitor (samples on the falling edge) ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_prev) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(out_data), int'(hold_data));
                check("hold_last", int'(out_last), int'(hold_last));
            end
            if (frm_valid) begin
                frm_cnt++;
                got_cmd = int'(frm_cmd);
                got_len = int'(frm_len);
                frm_cyc = cyc;
                check("frm_with_out", int'(out_valid), 0);
                check("frm_with_err", int'(err_valid), 0);
            end
            if (err_valid) begin
                err_cnt++;
                got_code = int'(err_code);
            end
            if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
            if (out_valid && out_ready) begin
                out_cnt++;
                last_out_cyc = cyc;
                if (out_last) last_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_extra actual=%02h required=no_byte", out_data);
                end else begin
                    check("out_data", int'(out_data), int'(exp_q[0]));
                    check("out_last", int'(out_last), int'(exp_q.size() == 1));
                    void'(exp_q.pop_front());
                end
            end
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
        end else begin
            hold_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic e);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_data  = d;
        rx_eop   = e;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clear_counts();
        frm_cnt       = 0;
        err_cnt       = 0;
        out_cnt       = 0;
        last_cnt      = 0;
        first_out_cyc = -1;
        got_cmd       = 0;
        got_len       = 0;
        got_code      = 0;
        exp_q.delete();
    endtask

    task automatic check_counts(input string t, input int efrm, input int ecmd, input int elen,
                                input int eerr, input int ecode, input int eout);
        check({t, "_frm_cnt"}, frm_cnt, efrm);
        if (efrm > 0) begin
            check({t, "_cmd"}, got_cmd, ecmd);
            check({t, "_len"}, got_len, elen);
        end
        check({t, "_err_cnt"}, err_cnt, eerr);
        if (eerr > 0) check({t, "_err_code"}, got_code, ecode);
        check({t, "_out_cnt"}, out_cnt, eout);
        check({t, "_last_cnt"}, last_cnt, int'(eout > 0));
        check({t, "_exp_left"}, exp_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         n;
        logic [7:0] b[8];
        logic       eop;
        int         off;
        int         exp_frm;
        int         exp_cmd;
        int         exp_len;
        int         exp_err;
        int         exp_code;
        int         exp_out;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] sum;
        logic [7:0] p;
        logic [7:0] chk;
        int         chk_cyc;

        vecs[0] = '{7, '{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9C, 8'h00}, 1'b0, 3, 1, 8'h01, 3, 0, 0, 3};
        vecs[1] = '{4, '{8'hA5, 8'h02, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 3, 1, 8'h02, 0, 0, 0, 0};
        vecs[2] = '{6, '{8'hA5, 8'h01, 8'h02, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00}, 1'b0, 3, 0, 0, 0, 1, 0, 0};
        vecs[3] = '{6, '{8'hA5, 8'h01, 8'h41, 8'h10, 8'h20, 8'h30, 8'h00, 8'h00}, 1'b0, 3, 0, 0, 0, 1, 1, 0};
        vecs[4] = '{5, '{8'hA5, 8'h01, 8'h04, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00}, 1'b1, 3, 0, 0, 0, 1, 2, 0};
        vecs[5] = '{7, '{8'h00, 8'hFF, 8'hA5, 8'h07, 8'h01, 8'h5A, 8'h9E, 8'h00}, 1'b0, 5, 1, 8'h07, 1, 0, 0, 1};
        vecs[6] = '{4, '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 3, 0, 0, 0, 1, 0, 0};
        vecs[7] = '{6, '{8'hA5, 8'hA5, 8'h02, 8'hA5, 8'h00, 8'hB4, 8'h00, 8'h00}, 1'b0, 3, 1, 8'hA5, 2, 0, 0, 2};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_frm_valid", int'(frm_valid), 0);
        check("rst_frm_cmd", int'(frm_cmd), 0);
        check("rst_frm_len", int'(frm_len), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_err_valid", int'(err_valid), 0);
        check("rst_err_code", int'(err_code), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven single frames
        for (int i = 0; i < 8; i++) begin
            clear_counts();
            if (vecs[i].exp_frm > 0) begin
                for (int k = 0; k < vecs[i].exp_len; k++) exp_q.push_back(vecs[i].b[vecs[i].off + k]);
            end
            for (int j = 0; j < vecs[i].n; j++) drive_cycle(1'b1, vecs[i].b[j], 1'b0);
            if (vecs[i].eop) drive_cycle(1'b0, 8'h00, 1'b1);
            drive_cycle(1'b0, 8'h00, 1'b0);
            wait_cycles(12);
            check_counts($sformatf("vec%0d", i), vecs[i].exp_frm, vecs[i].exp_cmd, vecs[i].exp_len,
                         vecs[i].exp_err, vecs[i].exp_code, vecs[i].exp_out);
        end

        // Reset in the middle of a frame discards it; the tail is ignored in IDLE
        clear_counts();
        drive_cycle(1'b1, 8'hA5, 1'b0);
        drive_cycle(1'b1, 8'h01, 1'b0);
        drive_cycle(1'b1, 8'h03, 1'b0);
        drive_cycle(1'b1, 8'h10, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        drive_cycle(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        drive_cycle(1'b1, 8'h20, 1'b0);
        drive_cycle(1'b1, 8'h30, 1'b0);
        drive_cycle(1'b1, 8'h9C, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b0);
        wait_cycles(8);
        check_counts("rst_mid", 0, 0, 0, 0, 0, 0);

        // eop in IDLE ignored; eop with a correct CHK byte in the same cycle aborts
        clear_counts();
        drive_cycle(1'b0, 8'h00, 1'b1);
        drive_cycle(1'b1, 8'hA5, 1'b0);
        drive_cycle(1'b1, 8'h01, 1'b0);
        drive_cycle(1'b1, 8'h01, 1'b0);
        drive_cycle(1'b1, 8'h33, 1'b0);
        drive_cycle(1'b1, 8'hCB, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b0);
        wait_cycles(8);
        check_counts("eop_same", 0, 0, 0, 1, 2, 0);

        clear_counts();
        exp_q.push_back(8'h33);
        drive_cycle(1'b1, 8'hA5, 1'b0);
        drive_cycle(1'b1, 8'h01, 1'b0);
        drive_cycle(1'b1, 8'h01, 1'b0);
        drive_cycle(1'b1, 8'h33, 1'b0);
        drive_cycle(1'b1, 8'hCB, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b0);
        wait_cycles(8);
        check_counts("after_eop", 1, 8'h01, 1, 0, 0, 1);

        // Largest accepted payload, latency and back-to-back streaming
        clear_counts();
        sum = 8'h09 + 8'h40;
        drive_cycle(1'b1, 8'hA5, 1'b0);
        drive_cycle(1'b1, 8'h09, 1'b0);
        drive_cycle(1'b1, 8'h40, 1'b0);
        for (int i = 0; i < 64; i++) begin
            p = 8'(i * 3 + 1);
            exp_q.push_back(p);
            sum = sum + p;
            drive_cycle(1'b1, p, 1'b0);
        end
        chk = 8'h00 - sum;
        drive_cycle(1'b1, chk, 1'b0);
        chk_cyc = cyc;
        drive_cycle(1'b0, 8'h00, 1'b0);
        wait_cycles(80);
        check_counts("maxlen", 1, 8'h09, 64, 0, 0, 64);
        check("lat_frm", frm_cyc - chk_cyc, 1);
        check("lat_out", first_out_cyc - chk_cyc, 2);
        check("no_bubbles", last_out_cyc - first_out_cyc, 63);

        // Stalled drain with a byte (even SYNC) arriving mid-drain
        clear_counts();
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        drive_cycle(1'b1, 8'hA5, 1'b0);
        drive_cycle(1'b1, 8'h05, 1'b0);
        drive_cycle(1'b1, 8'h04, 1'b0);
        drive_cycle(1'b1, 8'h01, 1'b0);
        drive_cycle(1'b1, 8'h02, 1'b0);
        drive_cycle(1'b1, 8'h03, 1'b0);
        drive_cycle(1'b1, 8'h04, 1'b0);
        drive_cycle(1'b1, 8'hED, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive_cycle(i == 2, 8'hA5, 1'b0);
            out_ready = (i % 2 == 0);
        end
        out_ready = 1'b1;
        drive_cycle(1'b0, 8'h00, 1'b0);
        wait_cycles(10);
        check_counts("toggle", 1, 8'h05, 4, 1, 3, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
